// File: rtl/race_lane_if.sv
// race_lane_if: race core control/status bundle (start, pause, step, speed in; score, timer, state, winner, done out)
interface race_lane_if #(
  parameter int NUM_CH = 2,
  parameter int DIGITS = 2
);
  logic                       start;
  logic                       pause;
  logic [NUM_CH-1:0]          step;
  logic [2*NUM_CH-1:0]        speed;
  logic [DIGITS*4*NUM_CH-1:0] score;
  logic [DIGITS*4-1:0]        timer;
  logic [1:0]                 state;
  logic [NUM_CH-1:0]          winner;
  logic                       done;
  modport master (output start, pause, step, speed, input score, timer, state, winner, done);
  modport slave (input start, pause, step, speed, output score, timer, state, winner, done);
endinterface

// File: rtl/race_lane_engine.sv
// race_lane_engine: BCD countdown race lanes with auto pacing, BCD elapsed timer, pause and winner/tie detection
// Ports: clk; reset (async, active-high); bus.slave carries start/pause/step/speed in and score/timer/state/winner/done out
module race_lane_engine #(
  parameter int                  NUM_CH    = 2,
  parameter int                  DIGITS    = 2,
  parameter logic [DIGITS*4-1:0] START_BCD = 'h32,
  parameter int                  TICK_DIV  = 50_000_000,
  parameter int                  AUTO_BASE = 66_666_667
) (
  input logic        clk,
  input logic        reset,
  race_lane_if.slave bus
);
  localparam int SW = DIGITS * 4;
  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(3 * AUTO_BASE);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;
  state_t                       state_q, state_d;
  logic [NUM_CH-1:0][SW-1:0]    score_q, score_d;
  logic [NUM_CH-1:0][AW-1:0]    auto_q, auto_d;
  logic [NUM_CH-1:0][1:0]       spd_q;
  logic [PW-1:0]                pre_q, pre_d;
  logic [SW-1:0]                timer_q, timer_d;
  logic [NUM_CH-1:0]            win_q, win_d, fin, req;
  logic                         done_q;
  function automatic logic [SW-1:0] bcd_dec(input logic [SW-1:0] v);
    logic b;
    b = 1'b1;
    bcd_dec = v;
    for (int k = 0; k < DIGITS; k++)
      if (b) begin
        if (v[k*4+:4] == 4'd0) bcd_dec[k*4+:4] = 4'd9;
        else begin
          bcd_dec[k*4+:4] = v[k*4+:4] - 4'd1;
          b = 1'b0;
        end
      end
  endfunction
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic c;
    c = 1'b1;
    bcd_inc = v;
    for (int k = 0; k < DIGITS; k++)
      if (c) begin
        if (v[k*4+:4] == 4'd9) bcd_inc[k*4+:4] = 4'd0;
        else begin
          bcd_inc[k*4+:4] = v[k*4+:4] + 4'd1;
          c = 1'b0;
        end
      end
  endfunction
  // An auto lane only ticks on a count reached under an unchanged speed code.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      req[i] = bus.speed[2*i+:2] == 2'd0 ? bus.step[i] :
               bus.speed[2*i+:2] == spd_q[i] &&
               auto_q[i] == AW'(int'(bus.speed[2*i+:2]) * AUTO_BASE - 1);
  end
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    auto_d  = auto_q;
    pre_d   = pre_q;
    timer_d = timer_q;
    win_d   = win_q;
    fin     = '0;
    if (bus.start && state_q != IDLE) begin
      state_d = bus.pause ? PAUSE : RUN;
      score_d = {NUM_CH{START_BCD}};
      auto_d  = '0;
      pre_d   = '0;
      timer_d = '0;
      win_d   = '0;
    end else if (state_q == IDLE) begin
      state_d = bus.start ? RUN : IDLE;
    end else if (state_q == PAUSE) begin
      state_d = bus.pause ? PAUSE : RUN;
    end else if (state_q == RUN) begin
      if (bus.pause) state_d = PAUSE;
      else begin
        pre_d = pre_q == PW'(TICK_DIV - 1) ? '0 : pre_q + 1'b1;
        timer_d = pre_q == PW'(TICK_DIV - 1) ? bcd_inc(timer_q) : timer_q;
        for (int i = 0; i < NUM_CH; i++) begin
          auto_d[i] = (bus.speed[2*i+:2] == 2'd0 || req[i]) ? '0 : auto_q[i] + 1'b1;
          if (req[i] && score_q[i] != '0) begin
            score_d[i] = bcd_dec(score_q[i]);
            fin[i] = score_q[i] == SW'(1);
          end
        end
        if (|fin) begin
          state_d = DONE;
          win_d = fin;
        end
      end
    end
    // A new speed code restarts that lane's pacing from zero in every state.
    for (int i = 0; i < NUM_CH; i++)
      if (bus.speed[2*i+:2] != spd_q[i]) auto_d[i] = '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      score_q <= {NUM_CH{START_BCD}};
      auto_q  <= '0;
      spd_q   <= '0;
      pre_q   <= '0;
      timer_q <= '0;
      win_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      auto_q  <= auto_d;
      spd_q   <= bus.speed;
      pre_q   <= pre_d;
      timer_q <= timer_d;
      win_q   <= win_d;
      done_q  <= state_d == DONE;
    end
  end
  assign bus.score  = score_q;
  assign bus.timer  = timer_q;
  assign bus.state  = state_q;
  assign bus.winner = win_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_race_lane_engine.sv
// tb_race_lane_engine: vector table plus hand sequences checking race_lane_engine through a scoreboard queue
module tb_race_lane_engine;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  race_lane_if #(.NUM_CH(2), .DIGITS(2)) bus ();
  race_lane_engine #(
    .NUM_CH(2), .DIGITS(2), .START_BCD(8'h12), .TICK_DIV(4), .AUTO_BASE(3)
  ) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct packed {
    logic [7:0] s0, s1, tmr;
    logic [1:0] st, win;
    logic       dn;
  } exp_t;
  typedef struct {
    logic       st, ps;
    logic [1:0] stp;
    logic [3:0] spd;
    exp_t       e;
  } vec_t;
  exp_t sb[$];
  vec_t tbl[$];
  int checks = 0;
  int errors = 0;
  function automatic exp_t mk(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] tmr,
                              input logic [1:0] st, input logic [1:0] win);
    exp_t e;
    e.s0 = s0; e.s1 = s1; e.tmr = tmr; e.st = st; e.win = win; e.dn = (st == 2'b11);
    return e;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask
  task automatic cmp_out(input exp_t e, input string tag);
    chk({tag, " score0"}, 32'(bus.score[7:0]), 32'(e.s0));
    chk({tag, " score1"}, 32'(bus.score[15:8]), 32'(e.s1));
    chk({tag, " timer"}, 32'(bus.timer), 32'(e.tmr));
    chk({tag, " state"}, 32'(bus.state), 32'(e.st));
    chk({tag, " winner"}, 32'(bus.winner), 32'(e.win));
    chk({tag, " done"}, 32'(bus.done), 32'(e.dn));
  endtask
  task automatic apply(input logic st, input logic ps, input logic [1:0] stp, input logic [3:0] spd,
                       input exp_t e, input string tag);
    exp_t got;
    bus.start = st; bus.pause = ps; bus.step = stp; bus.speed = spd;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.step = 2'b00;
    got = sb.pop_front();
    cmp_out(got, tag);
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic add(input logic st, input logic ps, input logic [1:0] stp, input logic [3:0] spd,
                     input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] tmr,
                     input logic [1:0] sta, input logic [1:0] win);
    vec_t v;
    v.st = st; v.ps = ps; v.stp = stp; v.spd = spd; v.e = mk(s0, s1, tmr, sta, win);
    tbl.push_back(v);
  endtask
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.start = 1'b0; bus.pause = 1'b0; bus.step = 2'b00; bus.speed = 4'h0;
    add(1,0,2'b00,4'h0, 8'h12,8'h12,8'h00,2'd1,2'b00);
    add(0,0,2'b01,4'h0, 8'h11,8'h12,8'h00,2'd1,2'b00);
    add(0,0,2'b00,4'h0, 8'h11,8'h12,8'h00,2'd1,2'b00);
    add(0,0,2'b01,4'h0, 8'h10,8'h12,8'h00,2'd1,2'b00);
    add(0,0,2'b01,4'h0, 8'h09,8'h12,8'h01,2'd1,2'b00);
    add(0,0,2'b10,4'h0, 8'h09,8'h11,8'h01,2'd1,2'b00);
    add(0,0,2'b11,4'h0, 8'h08,8'h10,8'h01,2'd1,2'b00);
    add(0,0,2'b00,4'h4, 8'h08,8'h10,8'h01,2'd1,2'b00);
    add(0,0,2'b00,4'h4, 8'h08,8'h10,8'h02,2'd1,2'b00);
    add(0,0,2'b00,4'h4, 8'h08,8'h10,8'h02,2'd1,2'b00);
    add(0,0,2'b00,4'h4, 8'h08,8'h09,8'h02,2'd1,2'b00);
    add(0,0,2'b10,4'h4, 8'h08,8'h09,8'h02,2'd1,2'b00);
    add(0,0,2'b00,4'h4, 8'h08,8'h09,8'h03,2'd1,2'b00);
    add(0,0,2'b00,4'h4, 8'h08,8'h08,8'h03,2'd1,2'b00);
    add(0,0,2'b10,4'h8, 8'h08,8'h08,8'h03,2'd1,2'b00);
    add(0,0,2'b10,4'h8, 8'h08,8'h08,8'h03,2'd1,2'b00);
    add(0,0,2'b00,4'h8, 8'h08,8'h08,8'h04,2'd1,2'b00);
    add(0,0,2'b10,4'h8, 8'h08,8'h08,8'h04,2'd1,2'b00);
    add(0,0,2'b00,4'h8, 8'h08,8'h08,8'h04,2'd1,2'b00);
    add(0,0,2'b00,4'h8, 8'h08,8'h08,8'h04,2'd1,2'b00);
    add(0,0,2'b00,4'h8, 8'h08,8'h07,8'h05,2'd1,2'b00);
    add(0,0,2'b01,4'h0, 8'h07,8'h07,8'h05,2'd1,2'b00);
    add(0,0,2'b11,4'h0, 8'h06,8'h06,8'h05,2'd1,2'b00);
    add(0,0,2'b11,4'h0, 8'h05,8'h05,8'h05,2'd1,2'b00);
    add(0,0,2'b11,4'h0, 8'h04,8'h04,8'h06,2'd1,2'b00);
    add(0,0,2'b11,4'h0, 8'h03,8'h03,8'h06,2'd1,2'b00);
    add(0,0,2'b11,4'h0, 8'h02,8'h02,8'h06,2'd1,2'b00);
    add(0,0,2'b11,4'h0, 8'h01,8'h01,8'h06,2'd1,2'b00);
    add(0,0,2'b11,4'h0, 8'h00,8'h00,8'h07,2'd3,2'b11);
    add(0,0,2'b11,4'h0, 8'h00,8'h00,8'h07,2'd3,2'b11);
    add(0,1,2'b01,4'h0, 8'h00,8'h00,8'h07,2'd3,2'b11);
    add(1,0,2'b00,4'h0, 8'h12,8'h12,8'h00,2'd1,2'b00);
    #2 reset = 1'b1;
    #1 cmp_out(mk(8'h12,8'h12,8'h00,2'd0,2'b00), "reset");
    @(posedge clk); #1 reset = 1'b0;
    apply(0,0,2'b01,4'h0, mk(8'h12,8'h12,8'h00,2'd0,2'b00), "idle_step");
    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i].st, tbl[i].ps, tbl[i].stp, tbl[i].spd, tbl[i].e, $sformatf("vec%0d", i));
    apply(1,0,2'b00,4'h3, mk(8'h12,8'h12,8'h00,2'd1,2'b00), "auto_start");
    idle(7);
    apply(0,0,2'b00,4'h3, mk(8'h12,8'h12,8'h02,2'd1,2'b00), "auto_pre");
    apply(0,0,2'b00,4'h3, mk(8'h11,8'h12,8'h02,2'd1,2'b00), "auto_first");
    apply(1,0,2'b00,4'h0, mk(8'h12,8'h12,8'h00,2'd1,2'b00), "restart");
    idle(39);
    apply(0,0,2'b00,4'h0, mk(8'h12,8'h12,8'h10,2'd1,2'b00), "timer40");
    for (int i = 0; i < 20; i++)
      apply(0,1,2'b01,4'h0, mk(8'h12,8'h12,8'h10,2'd2,2'b00), $sformatf("pause%0d", i));
    apply(0,0,2'b00,4'h0, mk(8'h12,8'h12,8'h10,2'd1,2'b00), "resume");
    idle(2);
    apply(0,0,2'b00,4'h0, mk(8'h12,8'h12,8'h10,2'd1,2'b00), "resume3");
    apply(0,0,2'b00,4'h0, mk(8'h12,8'h12,8'h11,2'd1,2'b00), "resume4");
    idle(351);
    apply(0,0,2'b00,4'h0, mk(8'h12,8'h12,8'h99,2'd1,2'b00), "timer99");
    idle(3);
    apply(0,0,2'b00,4'h0, mk(8'h12,8'h12,8'h00,2'd1,2'b00), "timer_wrap");
    apply(1,1,2'b00,4'h0, mk(8'h12,8'h12,8'h00,2'd2,2'b00), "start_paused");
    apply(0,0,2'b01,4'h0, mk(8'h12,8'h12,8'h00,2'd1,2'b00), "unpause");
    apply(0,0,2'b01,4'h0, mk(8'h11,8'h12,8'h00,2'd1,2'b00), "step_after");
    #2 reset = 1'b1;
    #1 cmp_out(mk(8'h12,8'h12,8'h00,2'd0,2'b00), "midrun_reset");
    @(posedge clk); #1 reset = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
